// File: rtl/icache_dm_ctrl_if.sv
// Core-side fetch and memory-side refill signals of the direct-mapped instruction cache.
// The cache uses the slave modport; the core/memory environment uses master.
interface icache_dm_ctrl_if #(
  parameter int WORDS_PER_LINE = 4
);
  logic                          cpu_req;
  logic [31:0]                   cpu_addr;
  logic                          flush;
  logic [31:0]                   cpu_instr;
  logic                          cpu_valid;
  logic                          cpu_err;
  logic                          cpu_stall;
  logic                          mem_req;
  logic [31:0]                   mem_addr;
  logic                          mem_ready;
  logic [32*WORDS_PER_LINE-1:0]  mem_line;
  logic [31:0]                   hit_count;
  logic [31:0]                   miss_count;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_ready, mem_line,
    output cpu_instr, cpu_valid, cpu_err, cpu_stall, mem_req, mem_addr,
           hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_ready, mem_line,
    input  cpu_instr, cpu_valid, cpu_err, cpu_stall, mem_req, mem_addr,
           hit_count, miss_count
  );
endinterface

// File: rtl/icache_dm_ctrl.sv
// Direct-mapped instruction cache controller with whole-line refill.
// Define ICACHE_STATS_EN to build saturating hit/miss counters; otherwise they read 0.
//
// state  | meaning
// IDLE   | accepting fetches; hits answered next cycle, misses start a refill
// REFILL | mem_req held, waiting for mem_ready to write the line
module icache_dm_ctrl #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input logic             clk,
  input logic             rst_n,
  icache_dm_ctrl_if.slave bus
);
  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TB = 30 - WB - IB;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_nxt;

  logic [1:0]    a_off;
  logic [WB-1:0] a_word;
  logic [IB-1:0] a_idx;
  logic [TB-1:0] a_tag;

  logic [NUM_LINES-1:0]         line_valid;
  logic [TB-1:0]                line_tag  [NUM_LINES];
  logic [32*WORDS_PER_LINE-1:0] line_data [NUM_LINES];

  logic [TB-1:0] fill_tag;
  logic [IB-1:0] fill_idx;
  logic [WB-1:0] fill_word;
  logic          mem_req_q;
  logic [31:0]   instr_q;
  logic          valid_q;
  logic          err_q;

  logic do_hit, do_miss, do_fill, do_err;

  assign a_off  = bus.cpu_addr[1:0];
  assign a_word = bus.cpu_addr[2 +: WB];
  assign a_idx  = bus.cpu_addr[2+WB +: IB];
  assign a_tag  = bus.cpu_addr[31 -: TB];

  always_comb begin
    state_nxt = state;
    do_hit    = 1'b0;
    do_miss   = 1'b0;
    do_fill   = 1'b0;
    do_err    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          if (a_off != 2'b00) begin
            do_err = 1'b1;
          end else if (!bus.flush && line_valid[a_idx] && (line_tag[a_idx] == a_tag)) begin
            do_hit = 1'b1;
          end else begin
            // a flush in the same cycle invalidates the line, so it counts as a miss
            do_miss   = 1'b1;
            state_nxt = REFILL;
          end
        end
      end
      REFILL: begin
        if (bus.mem_ready) begin
          do_fill   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_valid <= '0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      fill_word  <= '0;
      mem_req_q  <= 1'b0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= do_hit | do_fill;
      err_q   <= do_err;
      if (do_hit)
        instr_q <= line_data[a_idx][{a_word, 5'd0} +: 32];
      if (do_fill)
        instr_q <= bus.mem_line[{fill_word, 5'd0} +: 32];
      if (do_miss) begin
        mem_req_q <= 1'b1;
        fill_tag  <= a_tag;
        fill_idx  <= a_idx;
        fill_word <= a_word;
      end
      if (do_fill)
        mem_req_q <= 1'b0;
      // flush first so an in-flight refill still leaves its own line valid
      if (bus.flush)
        line_valid <= '0;
      if (do_fill)
        line_valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_fill) begin
      line_data[fill_idx] <= bus.mem_line;
      line_tag[fill_idx]  <= fill_tag;
    end
  end

  assign bus.cpu_instr = instr_q;
  assign bus.cpu_valid = valid_q;
  assign bus.cpu_err   = err_q;
  assign bus.cpu_stall = (state == REFILL);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = {fill_tag, fill_idx, {(WB+2){1'b0}}};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (do_hit && (hit_cnt != 32'hFFFF_FFFF))
        hit_cnt <= hit_cnt + 32'd1;
      if (do_miss && (miss_cnt != 32'hFFFF_FFFF))
        miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_icache_dm_ctrl.sv
// Directed self-checking bench for icache_dm_ctrl at default parameters.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_icache_dm_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  icache_dm_ctrl_if #(.WORDS_PER_LINE(4)) bus ();

  icache_dm_ctrl #(.NUM_LINES(8), .WORDS_PER_LINE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
  endtask

  function automatic logic [127:0] mk(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  logic [127:0] l1, l2, l3, l4;

  initial begin
    l1 = mk(32'h1111_0000, 32'h2008_0005, 32'h3333_0002, 32'h4444_0003);
    l2 = mk(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
    l3 = mk(32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003);
    l4 = mk(32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003);

    rst_n         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_line  = '0;
    #12;
    chk("rst_mem_req",   {31'd0, bus.mem_req},   32'd0);
    chk("rst_mem_addr",  bus.mem_addr,           32'd0);
    chk("rst_cpu_valid", {31'd0, bus.cpu_valid}, 32'd0);
    chk("rst_cpu_err",   {31'd0, bus.cpu_err},   32'd0);
    chk("rst_cpu_instr", bus.cpu_instr,          32'd0);
    chk("rst_stall",     {31'd0, bus.cpu_stall}, 32'd0);
    chk("rst_hit_count", bus.hit_count,          32'd0);
    chk("rst_miss_count", bus.miss_count,        32'd0);
    rst_n = 1'b1;
    tick();

    // first fetch misses; memory answers in the third refill cycle
    req(32'h0000_0104);
    tick();
    chk("m1_stall",    {31'd0, bus.cpu_stall}, 32'd1);
    chk("m1_mem_req",  {31'd0, bus.mem_req},   32'd1);
    chk("m1_mem_addr", bus.mem_addr,           32'h0000_0100);
    chk("m1_no_valid", {31'd0, bus.cpu_valid}, 32'd0);
    bus.cpu_req = 1'b0;
    tick();
    tick();
    chk("m1_req_held",  {31'd0, bus.mem_req}, 32'd1);
    chk("m1_addr_held", bus.mem_addr,         32'h0000_0100);
    chk("m1_no_valid_wait", {31'd0, bus.cpu_valid}, 32'd0);
    bus.mem_line  = l1;
    bus.mem_ready = 1'b1;
    tick();
    chk("m1_valid",     {31'd0, bus.cpu_valid}, 32'd1);
    chk("m1_instr",     bus.cpu_instr,          32'h2008_0005);
    chk("m1_req_drop",  {31'd0, bus.mem_req},   32'd0);
    chk("m1_stall_off", {31'd0, bus.cpu_stall}, 32'd0);
    bus.mem_ready = 1'b0;
    tick();
    chk("m1_valid_pulse", {31'd0, bus.cpu_valid}, 32'd0);
    chk("m1_instr_hold",  bus.cpu_instr,          32'h2008_0005);

    // hits on the refilled line
    req(32'h0000_0104);
    tick();
    chk("h1_valid",   {31'd0, bus.cpu_valid}, 32'd1);
    chk("h1_instr",   bus.cpu_instr,          32'h2008_0005);
    chk("h1_mem_req", {31'd0, bus.mem_req},   32'd0);
`ifdef ICACHE_STATS_EN
    chk("stat_hit_1",  bus.hit_count,  32'd1);
    chk("stat_miss_1", bus.miss_count, 32'd1);
`endif
    req(32'h0000_010C);
    tick();
    chk("h2_valid",   {31'd0, bus.cpu_valid}, 32'd1);
    chk("h2_instr",   bus.cpu_instr,          32'h4444_0003);
    chk("h2_mem_req", {31'd0, bus.mem_req},   32'd0);
    bus.cpu_req = 1'b0;

    // stray mem_ready while idle must do nothing
    bus.mem_ready = 1'b1;
    tick();
    chk("idle_ready_valid", {31'd0, bus.cpu_valid}, 32'd0);
    chk("idle_ready_stall", {31'd0, bus.cpu_stall}, 32'd0);
    bus.mem_ready = 1'b0;

    // conflicting tag at index 0 replaces the line
    req(32'h0000_0904);
    tick();
    chk("c1_mem_req",  {31'd0, bus.mem_req}, 32'd1);
    chk("c1_mem_addr", bus.mem_addr,         32'h0000_0900);
    bus.cpu_req   = 1'b0;
    bus.mem_line  = l2;
    bus.mem_ready = 1'b1;
    tick();
    chk("c1_valid", {31'd0, bus.cpu_valid}, 32'd1);
    chk("c1_instr", bus.cpu_instr,          32'hA000_0001);
    bus.mem_ready = 1'b0;
    req(32'h0000_0104);
    tick();
    chk("c2_remiss",   {31'd0, bus.mem_req},   32'd1);
    chk("c2_mem_addr", bus.mem_addr,           32'h0000_0100);
    chk("c2_no_valid", {31'd0, bus.cpu_valid}, 32'd0);
    bus.cpu_req   = 1'b0;
    bus.mem_line  = l1;
    bus.mem_ready = 1'b1;
    tick();
    chk("c2_instr", bus.cpu_instr, 32'h2008_0005);
    bus.mem_ready = 1'b0;

    // misaligned fetch
    req(32'h0000_0106);
    tick();
    chk("e1_err",     {31'd0, bus.cpu_err},   32'd1);
    chk("e1_valid",   {31'd0, bus.cpu_valid}, 32'd0);
    chk("e1_mem_req", {31'd0, bus.mem_req},   32'd0);
    bus.cpu_req = 1'b0;
    tick();
    chk("e1_err_pulse", {31'd0, bus.cpu_err}, 32'd0);

    // fill index 1, then flush during a refill of 0x200
    req(32'h0000_0110);
    tick();
    chk("f0_mem_addr", bus.mem_addr, 32'h0000_0110);
    bus.cpu_req   = 1'b0;
    bus.mem_line  = l4;
    bus.mem_ready = 1'b1;
    tick();
    chk("f0_instr", bus.cpu_instr, 32'hB000_0000);
    bus.mem_ready = 1'b0;
    req(32'h0000_0200);
    tick();
    chk("f1_mem_addr", bus.mem_addr, 32'h0000_0200);
    bus.cpu_req = 1'b0;
    bus.flush   = 1'b1;
    tick();
    chk("f1_stall_after_flush", {31'd0, bus.cpu_stall}, 32'd1);
    bus.flush     = 1'b0;
    bus.mem_line  = l3;
    bus.mem_ready = 1'b1;
    tick();
    chk("f1_valid", {31'd0, bus.cpu_valid}, 32'd1);
    chk("f1_instr", bus.cpu_instr,          32'hC000_0000);
    bus.mem_ready = 1'b0;
    req(32'h0000_0200);
    tick();
    chk("f2_hit_valid", {31'd0, bus.cpu_valid}, 32'd1);
    chk("f2_hit_instr", bus.cpu_instr,          32'hC000_0000);
    chk("f2_hit_noreq", {31'd0, bus.mem_req},   32'd0);
    req(32'h0000_0114);
    tick();
    chk("f3_flushed_miss", {31'd0, bus.mem_req}, 32'd1);
    bus.cpu_req   = 1'b0;
    bus.mem_line  = l4;
    bus.mem_ready = 1'b1;
    tick();
    chk("f3_instr", bus.cpu_instr, 32'hB000_0001);
    bus.mem_ready = 1'b0;
    req(32'h0000_0104);
    tick();
    chk("f4_miss", {31'd0, bus.mem_req}, 32'd1);
    bus.cpu_req   = 1'b0;
    bus.mem_line  = l1;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;

    // flush with a simultaneous request on a resident line counts as a miss
    req(32'h0000_0104);
    bus.flush = 1'b1;
    tick();
    chk("fi_miss",     {31'd0, bus.mem_req},   32'd1);
    chk("fi_no_valid", {31'd0, bus.cpu_valid}, 32'd0);
    bus.flush     = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.mem_line  = l1;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;

    // reset in the middle of a refill, memory answers late
    req(32'h0000_0300);
    tick();
    bus.cpu_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    chk("r_mem_req", {31'd0, bus.mem_req},   32'd0);
    chk("r_stall",   {31'd0, bus.cpu_stall}, 32'd0);
    chk("r_addr",    bus.mem_addr,           32'd0);
`ifdef ICACHE_STATS_EN
    chk("r_hit_count",  bus.hit_count,  32'd0);
    chk("r_miss_count", bus.miss_count, 32'd0);
`endif
    rst_n         = 1'b1;
    bus.mem_line  = l3;
    bus.mem_ready = 1'b1;
    tick();
    chk("r_late_no_valid", {31'd0, bus.cpu_valid}, 32'd0);
    chk("r_late_no_req",   {31'd0, bus.mem_req},   32'd0);
    bus.mem_ready = 1'b0;
    req(32'h0000_0114);
    tick();
    chk("r_idx1_invalid", {31'd0, bus.mem_req}, 32'd1);
    bus.cpu_req   = 1'b0;
    bus.mem_line  = l4;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    req(32'h0000_0104);
    tick();
    chk("r_idx0_invalid", {31'd0, bus.mem_req}, 32'd1);
    bus.cpu_req   = 1'b0;
    bus.mem_line  = l1;
    bus.mem_ready = 1'b1;
    tick();
    chk("r_refill_instr", bus.cpu_instr, 32'h2008_0005);
    bus.mem_ready = 1'b0;
    req(32'h0000_0104);
    tick();
    chk("r_hit_valid", {31'd0, bus.cpu_valid}, 32'd1);
    chk("r_hit_noreq", {31'd0, bus.mem_req},   32'd0);
`ifdef ICACHE_STATS_EN
    chk("r_stat_hit",  bus.hit_count,  32'd1);
    chk("r_stat_miss", bus.miss_count, 32'd2);
`else
    chk("nostat_hit",  bus.hit_count,  32'd0);
    chk("nostat_miss", bus.miss_count, 32'd0);
`endif
    bus.cpu_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache_dm_ctrl.md
ICACHE_DM_CTRL -- requirements
Module: icache_dm_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 8, meaning number of cache lines (power of 2, >=2).
REQ-002 The block SHALL have parameter WORDS_PER_LINE, default 4, meaning 32-bit words per line (power of 2, >=2).
REQ-003 The block SHALL have ports clk (input, 1): the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have rst_n (input, 1): reset, asynchronous and active-low.
REQ-005 The block SHALL have cpu_req (input, 1): fetch request.
REQ-006 The block SHALL have cpu_addr (input, 32): byte fetch address, held stable by the core while cpu_stall=1.
REQ-007 The block SHALL have flush (input, 1): invalidate all lines.
REQ-008 The block SHALL have cpu_instr (output, 32): returned instruction word.
REQ-009 The block SHALL have cpu_valid (output, 1): one-cycle pulse qualifying cpu_instr.
REQ-010 The block SHALL have cpu_err (output, 1): one-cycle pulse for a misaligned request.
REQ-011 The block SHALL have cpu_stall (output, 1): high while a miss is being serviced.
REQ-012 The block SHALL have mem_req (output, 1) and mem_addr (output, 32): line-refill request and line-aligned address.
REQ-013 The block SHALL have mem_ready (input, 1) and mem_line (input, 32*WORDS_PER_LINE): refill data, valid in the mem_ready cycle; word k at bits [32k+31:32k].
REQ-014 The block SHALL have hit_count and miss_count (output, 32 each): statistics counters (see Configuration).

Function
REQ-015 Address split SHALL be offset = cpu_addr[1:0], word = next log2(WORDS_PER_LINE) bits, index = next log2(NUM_LINES) bits, tag = remaining upper bits; each line SHALL store valid, tag, data.
REQ-016 The FSM SHALL have states IDLE and REFILL; cpu_stall SHALL equal (state==REFILL).
REQ-017 In IDLE with cpu_req=1 and offset!=0, the block SHALL pulse cpu_err the next cycle, not pulse cpu_valid, and not refill.
REQ-018 In IDLE with cpu_req=1, aligned, line valid and tag match (hit), the block SHALL, one cycle later, pulse cpu_valid with the addressed word on cpu_instr.
REQ-019 In IDLE with cpu_req=1, aligned, and no hit (miss), the block SHALL register mem_req=1 and mem_addr={cpu_addr[31:log2(4*WORDS_PER_LINE)], zeros} and enter REFILL.
REQ-020 In REFILL, mem_req and mem_addr SHALL be held until the cycle mem_ready=1; mem_ready in IDLE SHALL be ignored.
REQ-021 On mem_ready in REFILL, the block SHALL write mem_line, tag and valid=1 to the indexed line, drop mem_req, return to IDLE, and in the next cycle pulse cpu_valid with the requested word taken from mem_line (miss latency = refill cycles + 1).
REQ-022 A request arriving in the cycle REFILL returns to IDLE is not accepted; the core SHALL re-present it and it SHALL then hit.
REQ-023 cpu_instr SHALL hold its last value when cpu_valid=0.
REQ-024 flush in IDLE SHALL clear all valid bits in one cycle; a simultaneous cpu_req SHALL be treated as a miss.
REQ-025 flush in REFILL SHALL clear all valid bits; the in-flight refill SHALL still complete and leave its own line valid.

Reset
REQ-026 While rst_n=0: state=IDLE, all valid bits=0, mem_req=0, mem_addr=0, cpu_valid=0, cpu_err=0, cpu_instr=0, counters=0, asynchronously.
REQ-027 Reset asserted during REFILL SHALL abandon the refill with no line written; no cpu_valid SHALL follow.

Configuration
REQ-028 With macro ICACHE_STATS_EN defined, hit_count SHALL increment per REQ-018 hit and miss_count per REQ-019 miss, each saturating at 32'hFFFFFFFF.
REQ-029 Without ICACHE_STATS_EN, hit_count and miss_count SHALL be constant 0 and no counter registers SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then cpu_req at 0x0000_0104, mem_ready after 3 REFILL cycles with mem_line word1=0x2008_0005 -> mem_addr=0x0000_0100, cpu_valid with cpu_instr=0x2008_0005 one cycle after mem_ready.
REQ-031 Re-request 0x0000_0104 then 0x0000_010C -> both hit, cpu_valid next cycle, no mem_req, cpu_instr = words 1 and 3 of the refilled line.
REQ-032 Request 0x0000_0904 (same index, new tag, default params) -> miss, refill, replaces line; 0x0000_0104 then misses again.
REQ-033 cpu_req at 0x0000_0106 -> cpu_err pulse, no cpu_valid, mem_req stays 0.
REQ-034 flush during a REFILL for 0x0000_0200, then request 0x0000_0104 and 0x0000_0200 -> 0x0104 misses, 0x0200 hits.
REQ-035 rst_n low mid-REFILL, late mem_ready after release -> mem_req=0, no cpu_valid, all lines invalid; with ICACHE_STATS_EN, counters read 0 after reset and count 1 hit/1 miss for REQ-030/031 first two accesses.
